// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: command codes,
// channel states, BCD digit limits and the seven-segment decoder.
package timer_pkg;

  localparam logic [1:0] CMD_LOAD  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_PAUSE = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } ch_state_e;

  // Highest value of a units digit and of a minutes/seconds tens digit.
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] h_msb;
    logic [3:0] h_lsb;
    logic [3:0] m_msb;
    logic [3:0] m_lsb;
    logic [3:0] s_msb;
    logic [3:0] s_lsb;
  } bcd_time_t;

  // Active-low segments, bit6=a ... bit0=g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command bus of the countdown timer: one command per cycle plus the
// load-rejected pulse returned to the issuer.
interface countdown_timer_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            cmd_valid;
  logic [1:0]      cmd;
  logic [CH_W-1:0] cmd_ch;
  logic [3:0]      h_msb;
  logic [3:0]      h_lsb;
  logic [3:0]      m_msb;
  logic [3:0]      m_lsb;
  logic            load_err;

  modport master (
    output cmd_valid, cmd, cmd_ch, h_msb, h_lsb, m_msb, m_lsb,
    input  load_err
  );

  modport slave (
    input  cmd_valid, cmd, cmd_ch, h_msb, h_lsb, m_msb, m_lsb,
    output load_err
  );
endinterface

// File: rtl/countdown_channel.sv
// One countdown channel: run/pause/alarm state machine, HH:MM:SS BCD count
// with borrow chain, and LOAD value validation.
module countdown_channel
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [3:0] h_msb,
  input  logic [3:0] h_lsb,
  input  logic [3:0] m_msb,
  input  logic [3:0] m_lsb,
  output bcd_time_t  count,
  output logic       running,
  output logic       alarm,
  output logic       load_err
);

  ch_state_e state;
  bcd_time_t count_dec;

  function automatic logic load_ok(input logic [3:0] hm, input logic [3:0] hl,
                                   input logic [3:0] mm, input logic [3:0] ml);
    return (hm <= BCD_MAX) && (hl <= BCD_MAX) && (mm <= TENS_MAX) && (ml <= BCD_MAX);
  endfunction

  // Borrow ripples upward only while the lower digit is already zero.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s_lsb != 4'd0) r.s_lsb = t.s_lsb - 4'd1;
    else begin
      r.s_lsb = BCD_MAX;
      if (t.s_msb != 4'd0) r.s_msb = t.s_msb - 4'd1;
      else begin
        r.s_msb = TENS_MAX;
        if (t.m_lsb != 4'd0) r.m_lsb = t.m_lsb - 4'd1;
        else begin
          r.m_lsb = BCD_MAX;
          if (t.m_msb != 4'd0) r.m_msb = t.m_msb - 4'd1;
          else begin
            r.m_msb = TENS_MAX;
            if (t.h_lsb != 4'd0) r.h_lsb = t.h_lsb - 4'd1;
            else begin
              r.h_lsb = BCD_MAX;
              r.h_msb = t.h_msb - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  assign count_dec = bcd_dec(count);
  assign running   = (state == ST_RUN);

  // Commands take priority; a tick arriving with a command to this channel is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (cmd_valid) begin
        case (cmd)
          CMD_LOAD: begin
            if (load_ok(h_msb, h_lsb, m_msb, m_lsb)) begin
              count <= {h_msb, h_lsb, m_msb, m_lsb, 8'h00};
              state <= ST_IDLE;
              alarm <= 1'b0;
            end else begin
              load_err <= 1'b1;
            end
          end
          CMD_START: begin
            if ((state == ST_IDLE || state == ST_PAUSE) && count != '0) state <= ST_RUN;
          end
          CMD_PAUSE: begin
            if (state == ST_RUN) state <= ST_PAUSE;
          end
          CMD_CLEAR: begin
            state <= ST_IDLE;
            count <= '0;
            alarm <= 1'b0;
          end
          default: ;
        endcase
      end else if (tick && state == ST_RUN) begin
        count <= count_dec;
        if (count_dec == '0) begin
          state <= ST_ALARM;
          alarm <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Multi-channel countdown timer top: shared prescaler, command demux,
// per-channel instances, load_err merge and seven-segment display mux.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int N_CH    = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus,
  input  logic [CH_W-1:0]   disp_sel,
  output logic [6:0]        disp_h_msb,
  output logic [6:0]        disp_h_lsb,
  output logic [6:0]        disp_m_msb,
  output logic [6:0]        disp_m_lsb,
  output logic [6:0]        disp_s_msb,
  output logic [6:0]        disp_s_lsb,
  output logic [N_CH-1:0]   running,
  output logic [N_CH-1:0]   alarm
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0]   presc;
  logic            tick;
  logic [N_CH-1:0] ch_err;
  bcd_time_t       cnt [N_CH];
  bcd_time_t       shown;

  assign tick = (presc == PMAX);

  // Free-running prescaler shared by every channel; commands never touch it.
  always_ff @(posedge clk) begin
    if (!reset)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_cmd_valid;
    assign ch_cmd_valid = bus.cmd_valid && (bus.cmd_ch == CH_W'(i));

    countdown_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .cmd_valid (ch_cmd_valid),
      .cmd       (bus.cmd),
      .h_msb     (bus.h_msb),
      .h_lsb     (bus.h_lsb),
      .m_msb     (bus.m_msb),
      .m_lsb     (bus.m_lsb),
      .count     (cnt[i]),
      .running   (running[i]),
      .alarm     (alarm[i]),
      .load_err  (ch_err[i])
    );
  end

  // Only the addressed channel can reject a LOAD, so an OR suffices.
  assign bus.load_err = |ch_err;

  // Select the displayed channel; an unpopulated selector value shows zeros.
  always_comb begin
    shown = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (disp_sel == CH_W'(i)) shown = cnt[i];
    end
  end

  assign disp_h_msb = seg7(shown.h_msb);
  assign disp_h_lsb = seg7(shown.h_lsb);
  assign disp_m_msb = seg7(shown.m_msb);
  assign disp_m_lsb = seg7(shown.m_lsb);
  assign disp_s_msb = seg7(shown.s_msb);
  assign disp_s_lsb = seg7(shown.s_lsb);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (CLK_HZ=10, TICK_HZ=1, N_CH=4).
module tb_countdown_timer;

  localparam int DIV = 10;
  localparam logic [1:0] C_LOAD  = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_PAUSE = 2'd2;
  localparam logic [1:0] C_CLEAR = 2'd3;

  logic       clk;
  logic       reset;
  logic [1:0] disp_sel;
  logic [6:0] disp_h_msb, disp_h_lsb, disp_m_msb, disp_m_lsb, disp_s_msb, disp_s_lsb;
  logic [3:0] running;
  logic [3:0] alarm;

  countdown_timer_if #(.N_CH(4)) bus ();

  countdown_timer #(.CLK_HZ(10), .TICK_HZ(1), .N_CH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .disp_sel   (disp_sel),
    .disp_h_msb (disp_h_msb),
    .disp_h_lsb (disp_h_lsb),
    .disp_m_msb (disp_m_msb),
    .disp_m_lsb (disp_m_lsb),
    .disp_s_msb (disp_s_msb),
    .disp_s_lsb (disp_s_lsb),
    .running    (running),
    .alarm      (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  typedef struct {
    string       name;
    logic [3:0]  al;
    logic [3:0]  rn;
    logic        le;
    logic [23:0] bcd;
  } exp_t;

  typedef struct {
    string       name;
    logic        v;
    logic [1:0]  c;
    logic [1:0]  ch;
    logic [15:0] ld;
    logic [1:0]  sel;
    logic [3:0]  al;
    logic [3:0]  rn;
    logic        le;
    logic [23:0] bcd;
  } vec_t;

  exp_t sbq [$];
  vec_t tbl [$];
  int   errors = 0;
  int   checks = 0;

  // Reference prescaler: tick_m is high after an edge that carried a tick.
  int   pre;
  logic tick_m;
  always @(posedge clk) begin
    if (!reset) begin
      pre    <= 0;
      tick_m <= 1'b0;
    end else begin
      tick_m <= (pre == DIV - 1);
      pre    <= (pre == DIV - 1) ? 0 : pre + 1;
    end
  end

  function automatic logic [41:0] exp_disp(input logic [23:0] b);
    logic [41:0] r;
    logic [3:0]  d;
    r = '0;
    for (int i = 5; i >= 0; i--) begin
      d = b[i*4 +: 4];
      r = {r[34:0], (d <= 4'd9) ? segtab[d] : 7'b1111111};
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [1:0] ch, input logic [15:0] ld);
    bus.cmd_valid = v;
    bus.cmd       = c;
    bus.cmd_ch    = ch;
    {bus.h_msb, bus.h_lsb, bus.m_msb, bus.m_lsb} = ld;
  endtask

  task automatic sb_push(input string n, input logic [3:0] al, input logic [3:0] rn,
                         input logic le, input logic [23:0] bcd);
    exp_t e;
    e.name = n; e.al = al; e.rn = rn; e.le = le; e.bcd = bcd;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [41:0] act;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e   = sbq.pop_front();
    act = {disp_h_msb, disp_h_lsb, disp_m_msb, disp_m_lsb, disp_s_msb, disp_s_lsb};
    if (alarm !== e.al || running !== e.rn || bus.load_err !== e.le || act !== exp_disp(e.bcd)) begin
      errors++;
      $display("FAIL %s: got alarm=%b running=%b load_err=%b disp=%h, want alarm=%b running=%b load_err=%b disp=%h (%h)",
               e.name, alarm, running, bus.load_err, act, e.al, e.rn, e.le, exp_disp(e.bcd), e.bcd);
    end
  endtask

  task automatic chk(input string n, input logic [3:0] al, input logic [3:0] rn,
                     input logic le, input logic [23:0] bcd);
    sb_push(n, al, rn, le, bcd);
    sb_check();
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [1:0] ch, input logic [15:0] ld);
    drive(1'b1, c, ch, ld);
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int got = 0;
    for (int k = 0; k < n * DIV + DIV + 5 && got < n; k++) begin
      cyc();
      if (tick_m) got++;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL tick_wait: got %0d ticks, want %0d", got, n);
    end
  endtask

  task automatic add_vec(input string n, input logic v, input logic [1:0] c, input logic [1:0] ch,
                         input logic [15:0] ld, input logic [1:0] sel, input logic [3:0] al,
                         input logic [3:0] rn, input logic le, input logic [23:0] bcd);
    vec_t t;
    t.name = n; t.v = v; t.c = c; t.ch = ch; t.ld = ld; t.sel = sel;
    t.al = al; t.rn = rn; t.le = le; t.bcd = bcd;
    tbl.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Single-cycle command vectors on idle channels.
    add_vec("load_valid",   1'b1, C_LOAD,  2'd2, 16'h1234, 2'd2, 4'h0, 4'h0, 1'b0, 24'h123400);
    add_vec("load_m_msb6",  1'b1, C_LOAD,  2'd2, 16'h0060, 2'd2, 4'h0, 4'h0, 1'b1, 24'h123400);
    add_vec("load_h_lsbA",  1'b1, C_LOAD,  2'd2, 16'h0A00, 2'd2, 4'h0, 4'h0, 1'b1, 24'h123400);
    add_vec("err_one_cyc",  1'b0, C_LOAD,  2'd2, 16'h0000, 2'd2, 4'h0, 4'h0, 1'b0, 24'h123400);
    add_vec("load_m_lsbA",  1'b1, C_LOAD,  2'd2, 16'h000A, 2'd2, 4'h0, 4'h0, 1'b1, 24'h123400);
    add_vec("load_zero",    1'b1, C_LOAD,  2'd2, 16'h0000, 2'd2, 4'h0, 4'h0, 1'b0, 24'h000000);
    add_vec("start_zero",   1'b1, C_START, 2'd2, 16'h0000, 2'd2, 4'h0, 4'h0, 1'b0, 24'h000000);
    add_vec("load_max",     1'b1, C_LOAD,  2'd2, 16'h9959, 2'd2, 4'h0, 4'h0, 1'b0, 24'h995900);
    add_vec("clear",        1'b1, C_CLEAR, 2'd2, 16'h0000, 2'd2, 4'h0, 4'h0, 1'b0, 24'h000000);
    add_vec("view_ch1",     1'b0, C_LOAD,  2'd0, 16'h0000, 2'd1, 4'h0, 4'h0, 1'b0, 24'h000000);
    add_vec("pause_idle",   1'b1, C_PAUSE, 2'd1, 16'h0000, 2'd1, 4'h0, 4'h0, 1'b0, 24'h000000);

    drive(1'b0, C_LOAD, 2'd0, 16'h0000);
    disp_sel = 2'd0;
    reset    = 1'b0;
    cyc();
    cyc();
    chk("reset_state", 4'h0, 4'h0, 1'b0, 24'h000000);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].ch, tbl[i].ld);
      disp_sel = tbl[i].sel;
      sb_push(tbl[i].name, tbl[i].al, tbl[i].rn, tbl[i].le, tbl[i].bcd);
      cyc();
      sb_check();
    end
    bus.cmd_valid = 1'b0;

    // Basic countdown on ch0 from 00:01:00 to alarm.
    disp_sel = 2'd0;
    do_cmd(C_LOAD, 2'd0, 16'h0001);
    chk("ch0_load", 4'h0, 4'h0, 1'b0, 24'h000100);
    do_cmd(C_START, 2'd0, 16'h0000);
    chk("ch0_start", 4'h0, 4'h1, 1'b0, 24'h000100);
    wait_ticks(59);
    chk("ch0_59_ticks", 4'h0, 4'h1, 1'b0, 24'h000001);
    wait_ticks(1);
    chk("ch0_alarm", 4'h1, 4'h0, 1'b0, 24'h000000);
    wait_ticks(2);
    chk("ch0_alarm_hold", 4'h1, 4'h0, 1'b0, 24'h000000);
    do_cmd(C_CLEAR, 2'd0, 16'h0000);
    chk("ch0_clear", 4'h0, 4'h0, 1'b0, 24'h000000);

    // Full borrow chain on ch1, then pause and resume.
    disp_sel = 2'd1;
    do_cmd(C_LOAD, 2'd1, 16'h1000);
    chk("ch1_load", 4'h0, 4'h0, 1'b0, 24'h100000);
    do_cmd(C_START, 2'd1, 16'h0000);
    chk("ch1_start", 4'h0, 4'h2, 1'b0, 24'h100000);
    wait_ticks(1);
    chk("ch1_borrow", 4'h0, 4'h2, 1'b0, 24'h095959);
    do_cmd(C_PAUSE, 2'd1, 16'h0000);
    chk("ch1_pause", 4'h0, 4'h0, 1'b0, 24'h095959);
    wait_ticks(50);
    chk("ch1_frozen", 4'h0, 4'h0, 1'b0, 24'h095959);
    do_cmd(C_START, 2'd1, 16'h0000);
    chk("ch1_resume", 4'h0, 4'h2, 1'b0, 24'h095959);
    wait_ticks(1);
    chk("ch1_resumed_dec", 4'h0, 4'h2, 1'b0, 24'h095958);

    // Command on the tick edge: ch3 keeps its count, ch0 decrements.
    disp_sel = 2'd3;
    do_cmd(C_LOAD, 2'd3, 16'h0005);
    chk("ch3_load", 4'h0, 4'h2, 1'b0, 24'h000500);
    do_cmd(C_LOAD, 2'd0, 16'h0005);
    for (int k = 0; k < 2 * DIV && !tick_m; k++) cyc();
    do_cmd(C_START, 2'd0, 16'h0000);
    chk("ch0_start2", 4'h0, 4'h3, 1'b0, 24'h000500);
    do_cmd(C_START, 2'd3, 16'h0000);
    chk("ch3_start", 4'h0, 4'hB, 1'b0, 24'h000500);
    for (int k = 0; k < 2 * DIV && pre != DIV - 1; k++) cyc();
    do_cmd(C_PAUSE, 2'd3, 16'h0000);
    chk("ch3_collision", 4'h0, 4'h3, 1'b0, 24'h000500);
    disp_sel = 2'd0;
    #1;
    chk("ch0_parallel_dec", 4'h0, 4'h3, 1'b0, 24'h000459);

    // Reset while channels are running.
    reset = 1'b0;
    cyc();
    cyc();
    chk("reset_mid_ch0", 4'h0, 4'h0, 1'b0, 24'h000000);
    disp_sel = 2'd1;
    #1;
    chk("reset_mid_ch1", 4'h0, 4'h0, 1'b0, 24'h000000);
    reset = 1'b1;
    wait_ticks(3);
    chk("after_reset", 4'h0, 4'h0, 1'b0, 24'h000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Parametrised multi-channel countdown timer: the next generation of the single-channel digital alarm block. Each of N_CH channels holds an HH:MM:SS BCD count that decrements once per second from a shared prescaler, under a per-channel run/pause/alarm state machine. It raises a latched per-channel alarm at zero and drives six active-low seven-segment digits for a selectable channel.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- TICK_HZ, 1, count rate; CLK_HZ/TICK_HZ must be an integer of at least 2
- N_CH, 4, number of independent channels, 1..16
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command strobe, one command per cycle
- cmd  in  2  0=LOAD, 1=START, 2=PAUSE, 3=CLEAR
- cmd_ch  in  $clog2(N_CH) (min 1)  channel addressed by cmd
- h_msb, h_lsb, m_msb, m_lsb  in  4 each  BCD load value, used by LOAD only
- load_err  out  1  one-cycle pulse: LOAD rejected (invalid BCD)
- disp_sel  in  $clog2(N_CH) (min 1)  channel shown on displays
- disp_h_msb, disp_h_lsb, disp_m_msb, disp_m_lsb, disp_s_msb, disp_s_lsb  out  7 each  active-low segments, bit6=a … bit0=g
- running  out  N_CH  channel in RUN
- alarm  out  N_CH  latched alarm per channel

## Operation
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 and wraps; `tick` is high for one cycle at the wrap. Shared by all channels and never reset by commands.
- Channel states: IDLE, RUN, PAUSE, ALARM.
- LOAD (any state): validation rule is every digit ≤9 and m_msb ≤5.
  - Valid: count ← HH:MM:00, state ← IDLE, alarm cleared.
  - Invalid: state and count unchanged, load_err pulses.
- START: IDLE or PAUSE → RUN if count ≠ 0. Ignored in RUN, ALARM, or with a zero count.
- PAUSE: RUN → PAUSE. Ignored otherwise.
- CLEAR: any state → IDLE; count ← 0; alarm ← 0.
- Decrement on tick in RUN, with BCD borrow chain s_lsb → s_msb (5) → m_lsb → m_msb (5) → h_lsb → h_msb (9). Hours range 00–99.
- When a decrement yields 00:00:00: state ← ALARM, alarm[ch] ← 1, running[ch] ← 0. The count stays 0 until LOAD or CLEAR.
- Simultaneous command and tick on the addressed channel: the command wins and the tick is dropped for that channel that cycle. Other channels decrement normally.
- Display: combinational decode of channel disp_sel. Codes 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any other value shows 1111111 (blank).

## Timing
- Reset (reset=0 at a clk edge):
  - all counts 0, all states IDLE, prescaler 0
  - alarm=0, running=0, load_err=0
  - all displays 0000001
  - Reset mid-count aborts without an alarm.
- Command latency: state, count, running and alarm update on the edge that samples cmd_valid, so they are visible the next cycle. load_err is valid in that same next cycle.
- Alarm asserts the cycle after the tick that reaches zero.
- First tick after reset: CLK_HZ/TICK_HZ cycles after reset deasserts. START is not phase-aligned, so the first decrement after START lands within 1..CLK_HZ/TICK_HZ cycles.
- Display: combinational from registered state; a disp_sel change takes effect in the same cycle.

## Structure
- Package timer_pkg holds:
  - cmd encodings (CMD_LOAD/START/PAUSE/CLEAR)
  - channel state enum
  - seven-segment code constants and the decode function
  - the BCD digit limit constants
- Sub-module countdown_channel holds one channel's state machine, BCD count, borrow chain and load validation. It is instantiated N_CH times in a generate loop.
- The top level holds the prescaler, command demux, display mux/decoders and the load_err OR.

## Test plan
- Bench parameters: CLK_HZ=10, TICK_HZ=1, N_CH=4.
- Reset state: reset low for 2 cycles → alarm=0000, running=0000, all disp=0000001.
- Basic countdown: LOAD ch0 00:01, START → count reaches 00:00:00 after 60 ticks (600 cycles) → alarm[0]=1 the next cycle, running[0]=0. CLEAR → alarm[0]=0.
- Borrow chain: LOAD ch1 10:00, START, 1 tick → displays 09:59 with seconds 59.
- Pause and resume: PAUSE for 50 ticks → count frozen; START → count resumes.
- Invalid and zero loads: LOAD ch2 with m_msb=6 → load_err pulses, state unchanged. LOAD 00:00 then START → stays IDLE, no alarm.
- Command/tick collision: PAUSE ch3 issued on the tick cycle → ch3 not decremented; ch0 running in parallel decrements.
- Reset mid-run: reset during RUN → all channels IDLE, count 0, no alarm.
